lif_spike_monitor: RTL

LIF_SPIKE_MONITOR -- requirements
Module: lif_spike_monitor

---
 rtl/lif_spike_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor
//   Windowed activity monitor for one LIF neuron. Over each window of
//   2^WINDOW_LOG2 enabled cycles it counts spike events (rising edges of
//   spike_in), tracks the peak membrane state, and keeps the most recent
//   inter-spike interval. At window close it hands a result record out over
//   a valid/ready interface; a record that cannot be accepted is dropped
//   and flagged.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   en         in   measurement enable (low freezes all accumulation)
//   spike_in   in   spike flag from the neuron
//   state_in   in   [7:0] membrane state, unsigned
//   out_ready  in   consumer ready
//   out_valid  out  result record valid
//   rate_out   out  [7:0] spike count of completed window (saturating)
//   isi_out    out  [7:0] last inter-spike interval in cycles (saturating)
//   peak_out   out  [7:0] peak state_in of completed window
//   overflow   out  sticky: a window record was dropped
module lif_spike_monitor #(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       spike_in,
  input  logic [7:0] state_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] rate_out,
  output logic [7:0] isi_out,
  output logic [7:0] peak_out,
  output logic       overflow
);

  typedef enum logic {
    NO_REF,
    TIMING
  } isi_state_t;

  isi_state_t state, state_next;

  logic                   prev_spike;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [7:0]             spike_cnt;
  logic [7:0]             peak;
  logic [7:0]             interval;
  logic [7:0]             last_isi;

  logic [7:0] interval_next;
  logic [7:0] last_isi_next;
  logic [7:0] snap_rate;
  logic [7:0] snap_peak;
  logic       spike_ev;
  logic       close;
  logic       load;
  logic       drop;

  // Edge detect is qualified by en so a paused monitor sees no events,
  // while prev_spike keeps tracking the input every cycle.
  assign spike_ev = en & spike_in & ~prev_spike;
  assign close    = en & (win_cnt == '1);
  assign load     = close & (~out_valid | out_ready);
  assign drop     = close & out_valid & ~out_ready;

  // The snapshot folds in the closing cycle's own spike and sample.
  assign snap_rate = (spike_ev && spike_cnt != 8'hFF) ? spike_cnt + 8'd1 : spike_cnt;
  assign snap_peak = (state_in > peak) ? state_in : peak;

  // ISI FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NO_REF;
    end else begin
      state <= state_next;
    end
  end

  // ISI FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      NO_REF:  if (spike_ev) state_next = TIMING;
      TIMING:  state_next = TIMING;
      default: state_next = NO_REF;
    endcase
  end

  // ISI FSM: interval / last-ISI updates
  always_comb begin
    interval_next = interval;
    last_isi_next = last_isi;
    case (state)
      NO_REF: begin
        if (spike_ev) interval_next = '0;
      end
      TIMING: begin
        if (spike_ev) begin
          last_isi_next = (interval == 8'hFF) ? 8'hFF : interval + 8'd1;
          interval_next = '0;
        end else if (en && interval != 8'hFF) begin
          interval_next = interval + 8'd1;
        end
      end
      default: begin
        interval_next = '0;
      end
    endcase
  end

  // Window accumulation and output record
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_spike <= 1'b0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      peak       <= '0;
      interval   <= '0;
      last_isi   <= '0;
      out_valid  <= 1'b0;
      rate_out   <= '0;
      isi_out    <= '0;
      peak_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_spike <= spike_in;
      interval   <= interval_next;
      last_isi   <= last_isi_next;

      if (en) begin
        win_cnt <= win_cnt + WINDOW_LOG2'(1);
        if (close) begin
          spike_cnt <= '0;
          peak      <= '0;
        end else begin
          spike_cnt <= snap_rate;
          peak      <= snap_peak;
        end
      end

      // A load in the same cycle as an accept keeps out_valid asserted.
      if (load) begin
        out_valid <= 1'b1;
        rate_out  <= snap_rate;
        isi_out   <= last_isi_next;
        peak_out  <= snap_peak;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) overflow <= 1'b1;
    end
  end

endmodule
